// File: rtl/jump_pkg.sv
// Shared definitions for the jump game datapath and its controller.
//   - VEL_W       : width of velocity and distance values
//   - V_*_DEF     : default charge parameters, also used by jump and the display
//   - jump_state_e: controller state encoding, visible on jump_seq_ctrl.o_state
package jump_pkg;

  localparam int VEL_W = 11;

  localparam int V_MIN_DEF  = 32;
  localparam int V_MAX_DEF  = 255;
  localparam int V_STEP_DEF = 2;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CHARGE   = 3'd1,
    ST_LAUNCH   = 3'd2,
    ST_AIR      = 3'd3,
    ST_JUDGE    = 3'd4,
    ST_COOLDOWN = 3'd5
  } jump_state_e;

endpackage

// File: rtl/jump_charge_acc.sv
// Saturating charge accumulator for the launch velocity.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   clr      : force value to 0 (highest priority)
//   load     : load V_MIN
//   step_en  : add V_STEP, saturating at V_MAX
//   value    : current accumulated velocity
// V_MAX must not exceed 2**VEL_W - 1.
module jump_charge_acc
  import jump_pkg::*;
#(
  parameter int V_MIN  = V_MIN_DEF,
  parameter int V_MAX  = V_MAX_DEF,
  parameter int V_STEP = V_STEP_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic             step_en,
  output logic [VEL_W-1:0] value
);

  // One extra bit so value + V_STEP cannot wrap before the saturation test.
  localparam int SUM_W = VEL_W + 1;

  localparam logic [SUM_W-1:0] MAX_SUM  = SUM_W'(V_MAX);
  localparam logic [VEL_W-1:0] MAX_VAL  = VEL_W'(V_MAX);
  localparam logic [VEL_W-1:0] MIN_VAL  = VEL_W'(V_MIN);
  localparam logic [SUM_W-1:0] STEP_VAL = SUM_W'(V_STEP);

  logic [SUM_W-1:0] sum;

  assign sum = {1'b0, value} + STEP_VAL;

  // NOTE: registers are written with non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (load) begin
      value <= MIN_VAL;
    end else if (step_en) begin
      value <= (sum > MAX_SUM) ? MAX_VAL : sum[VEL_W-1:0];
    end
  end

endmodule

// File: rtl/jump_seq_ctrl.sv
// Sequencing controller for the jump physics datapath: charges a launch
// velocity while the button is held, runs one jump, judges the landing
// distance against the platform window and cools down before the next press.
// Ports:
//   clk_jump, rst          : jump tick clock, synchronous active-high reset
//   i_press                : debounced button level
//   i_jump_done/i_jump_dist: landing report from jump
//   i_target_min/max       : inclusive landing window
//   o_jump_en, o_v_init    : enable and launch velocity to jump
//   o_last_dist            : distance latched at the last real landing
//   o_land_ok/o_land_fail  : one-cycle result pulses (during JUDGE)
//   o_busy, o_state        : status for the game-state logic
module jump_seq_ctrl
  import jump_pkg::*;
#(
  parameter int V_MIN    = V_MIN_DEF,
  parameter int V_MAX    = V_MAX_DEF,
  parameter int V_STEP   = V_STEP_DEF,
  parameter int TIMEOUT  = 1023,
  parameter int COOL_CYC = 4
) (
  input  logic             clk_jump,
  input  logic             rst,
  input  logic             i_press,
  input  logic             i_jump_done,
  input  logic [VEL_W-1:0] i_jump_dist,
  input  logic [VEL_W-1:0] i_target_min,
  input  logic [VEL_W-1:0] i_target_max,
  output logic             o_jump_en,
  output logic [VEL_W-1:0] o_v_init,
  output logic [VEL_W-1:0] o_last_dist,
  output logic             o_land_ok,
  output logic             o_land_fail,
  output logic             o_busy,
  output logic [2:0]       o_state
);

  localparam int TMO_W  = $clog2(TIMEOUT + 1);
  localparam int COOL_W = $clog2(COOL_CYC + 1);

  // Counters compare against the last value so AIR lasts exactly TIMEOUT
  // cycles and COOLDOWN exactly COOL_CYC cycles.
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT - 1);
  localparam logic [COOL_W-1:0] COOL_LAST = COOL_W'(COOL_CYC - 1);

  jump_state_e       state, state_next;
  logic              press_d;
  logic              press_rise;
  logic              in_window;
  logic [TMO_W-1:0]  tmo_cnt, tmo_next;
  logic [COOL_W-1:0] cool_cnt, cool_next;
  logic              jump_en_next;
  logic              land_ok_next, land_fail_next;
  logic [VEL_W-1:0]  last_dist_next;
  logic              acc_clr, acc_load, acc_step;

  assign press_rise = i_press & ~press_d;
  // An inverted window (min > max) can never contain a distance, so it
  // naturally judges every landing a fail.
  assign in_window  = (i_jump_dist >= i_target_min) && (i_jump_dist <= i_target_max);
  assign o_state    = state;

  jump_charge_acc #(
    .V_MIN  (V_MIN),
    .V_MAX  (V_MAX),
    .V_STEP (V_STEP)
  ) u_charge_acc (
    .clk     (clk_jump),
    .rst     (rst),
    .clr     (acc_clr),
    .load    (acc_load),
    .step_en (acc_step),
    .value   (o_v_init)
  );

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_next     = state;
    jump_en_next   = o_jump_en;
    land_ok_next   = 1'b0;
    land_fail_next = 1'b0;
    last_dist_next = o_last_dist;
    tmo_next       = tmo_cnt;
    cool_next      = cool_cnt;
    acc_clr        = 1'b0;
    acc_load       = 1'b0;
    acc_step       = 1'b0;

    case (state)
      ST_IDLE: begin
        jump_en_next = 1'b0;
        if (press_rise) begin
          state_next = ST_CHARGE;
          acc_load   = 1'b1;
        end
      end

      ST_CHARGE: begin
        if (i_press) begin
          acc_step = 1'b1;
        end else begin
          state_next   = ST_LAUNCH;
          jump_en_next = 1'b1;
        end
      end

      // i_jump_done may still reflect the previous jump here, so it is ignored.
      ST_LAUNCH: begin
        state_next = ST_AIR;
        tmo_next   = '0;
      end

      ST_AIR: begin
        if (i_jump_done) begin
          // A real landing beats a timeout on the same edge.
          state_next     = ST_JUDGE;
          jump_en_next   = 1'b0;
          last_dist_next = i_jump_dist;
          land_ok_next   = in_window;
          land_fail_next = ~in_window;
        end else if (tmo_cnt == TMO_LAST) begin
          state_next     = ST_JUDGE;
          jump_en_next   = 1'b0;
          land_fail_next = 1'b1;
        end else begin
          tmo_next = tmo_cnt + 1'b1;
        end
      end

      ST_JUDGE: begin
        state_next = ST_COOLDOWN;
        cool_next  = '0;
      end

      // Holding jump_en low lets jump re-initialise; presses are ignored and
      // press_d keeps tracking, so a press held through here needs a fresh edge.
      ST_COOLDOWN: begin
        jump_en_next = 1'b0;
        if (cool_cnt == COOL_LAST) begin
          state_next = ST_IDLE;
          acc_clr    = 1'b1;
        end else begin
          cool_next = cool_cnt + 1'b1;
        end
      end

      default: begin
        state_next   = ST_IDLE;
        jump_en_next = 1'b0;
        acc_clr      = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_jump) begin
    if (rst) begin
      state       <= ST_IDLE;
      press_d     <= 1'b0;
      tmo_cnt     <= '0;
      cool_cnt    <= '0;
      o_jump_en   <= 1'b0;
      o_last_dist <= '0;
      o_land_ok   <= 1'b0;
      o_land_fail <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      state       <= state_next;
      press_d     <= i_press;
      tmo_cnt     <= tmo_next;
      cool_cnt    <= cool_next;
      o_jump_en   <= jump_en_next;
      o_last_dist <= last_dist_next;
      o_land_ok   <= land_ok_next;
      o_land_fail <= land_fail_next;
      o_busy      <= (state_next != ST_IDLE);
    end
  end

endmodule
